// File: rtl/picorv_memsim_pkg.sv
// Shared constants and types for the picorv_core memory/MMIO model.
// Wait-mode selectors, LFSR feedback taps and the address region decode.
package picorv_memsim_pkg;

  localparam int WAIT_NONE   = 0;
  localparam int WAIT_FIXED  = 1;
  localparam int WAIT_RANDOM = 2;

  // Right-shifting Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_CONSOLE,
    REGION_UNMAPPED
  } region_e;

endpackage

// File: rtl/picorv_lfsr16.sv
// 16-bit Fibonacci LFSR with loadable seed and step enable.
// Small enough to reuse wherever a bench needs cheap pseudo-random arbitration.
module picorv_lfsr16
  import picorv_memsim_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = ^(state & LFSR_TAPS);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= seed;
    end else if (en) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/picorv_memsim.sv
// Memory and MMIO model for the picorv_core native interface: byte-lane RAM,
// console/EOF port, configurable wait states, stall watchdog and bus-error flag.
module picorv_memsim
  import picorv_memsim_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               MEM_BYTES    = 2**20,
  parameter string            HEXFILE      = "",
  parameter logic [XLEN-1:0]  CONSOLE_ADDR = XLEN'(2**20),
  parameter int               WAIT_MODE    = WAIT_RANDOM,
  parameter int               FIXED_WAIT   = 2,
  parameter logic [3:0]       RAND_MASK    = 4'b0001,
  parameter logic [15:0]      LFSR_SEED    = 16'hACE1,
  parameter int               STALL_LIMIT  = 100
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_insn,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic [31:0]     mem_rdata,
  output logic            con_valid,
  output logic [7:0]      con_data,
  output logic            eof,
  output logic            stalled,
  output logic            bus_err,
  output logic [31:0]     fetch_cnt
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [31:0] STALL_MAX = 32'(STALL_LIMIT);

  logic [15:0]     lfsr_state;
  logic [3:0]      wait_cnt;
  logic            handshake;
  logic [XLEN-1:0] word;
  logic [AW-1:2]   line;
  region_e         region;
  logic [31:0]     ram_word;
  logic [31:0]     idle_cnt;
  logic            unused_bits;

  logic [7:0] ram [MEM_BYTES];

  function automatic logic [3:0] wait_value(input logic [3:0] rnd);
    if (WAIT_MODE == WAIT_NONE)       return 4'd0;
    else if (WAIT_MODE == WAIT_FIXED) return 4'(FIXED_WAIT);
    else                              return rnd & RAND_MASK;
  endfunction

  picorv_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .en    (1'b1),
    .state (lfsr_state)
  );

  assign unused_bits = ^lfsr_state[15:4];

  assign mem_ready = mem_valid && (wait_cnt == 4'd0) && !reset;
  assign handshake = mem_valid && mem_ready;

  assign word = mem_addr & ~XLEN'(3);
  assign line = word[AW-1:2];

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    region = REGION_UNMAPPED;
    if (word < XLEN'(MEM_BYTES))     region = REGION_RAM;
    else if (word == CONSOLE_ADDR)   region = REGION_CONSOLE;
  end

  // Console and unmapped reads fall through to zero.
  always_comb begin
    ram_word = '0;
    if (region == REGION_RAM) begin
      for (int i = 0; i < 4; i++) ram_word[8*i +: 8] = ram[{line, 2'(i)}];
    end
  end

`ifdef SIM
  assign mem_rdata = mem_ready ? ram_word : 'x;
`else
  assign mem_rdata = mem_ready ? ram_word : '0;
`endif

  // NOTE: RAM is deliberately left out of reset so a preloaded image survives it.
  always_ff @(posedge clock) begin
    if (handshake && region == REGION_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[{line, 2'(i)}] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // A dropped request keeps its remaining count so waits are never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= wait_value(LFSR_SEED[3:0]);
    end else if (handshake) begin
      wait_cnt <= wait_value(lfsr_state[3:0]);
    end else if (mem_valid && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      con_valid <= 1'b0;
      con_data  <= 8'h00;
      eof       <= 1'b0;
      bus_err   <= 1'b0;
      stalled   <= 1'b0;
      idle_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      con_valid <= 1'b0;
      if (handshake && region == REGION_CONSOLE && mem_wstrb[0]) begin
        if (mem_wdata[7:0] != 8'h00) begin
          con_valid <= 1'b1;
          con_data  <= mem_wdata[7:0];
        end else begin
          eof <= 1'b1;
        end
      end
      if (handshake && region == REGION_UNMAPPED) bus_err <= 1'b1;
      if (handshake && mem_insn) fetch_cnt <= fetch_cnt + 32'd1;

      if (mem_valid)                idle_cnt <= '0;
      else if (idle_cnt <= STALL_MAX) idle_cnt <= idle_cnt + 32'd1;
      if (idle_cnt > STALL_MAX)     stalled  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_picorv_memsim.sv
// Scoreboard bench for picorv_memsim: three instances (zero, fixed-3 and random
// waits) driven by a request task and checked by an independent monitor.
module tb_picorv_memsim;

  localparam int          MEM  = 65536;
  localparam logic [31:0] CON  = 32'h0010_0000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mem_valid = '0, mem_insn = '0;
  logic [2:0]  mem_ready, con_valid, eof, stalled, bus_err;
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_wstrb [3];
  logic [31:0] mem_rdata [3];
  logic [7:0]  con_data [3];
  logic [31:0] fetch_cnt [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    picorv_memsim #(
      .MEM_BYTES    (MEM),
      .CONSOLE_ADDR (CON),
      .WAIT_MODE    (g),
      .FIXED_WAIT   (3),
      .RAND_MASK    (4'b0011),
      .LFSR_SEED    (SEED),
      .STALL_LIMIT  (100)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .mem_valid (mem_valid[g]),
      .mem_ready (mem_ready[g]),
      .mem_insn  (mem_insn[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wstrb (mem_wstrb[g]),
      .mem_rdata (mem_rdata[g]),
      .con_valid (con_valid[g]),
      .con_data  (con_data[g]),
      .eof       (eof[g]),
      .stalled   (stalled[g]),
      .bus_err   (bus_err[g]),
      .fetch_cnt (fetch_cnt[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          dev;
    logic [31:0] rdata;
    bit          is_read;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ram_m [int];
  logic [15:0] m_lfsr;
  logic [3:0]  m_wait [3];
  int          busy [3];
  bit [3:0]    waits_seen = '0;
  logic [7:0]  con_seen[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Wait loaded after each handshake: none, fixed 3, or two low LFSR bits.
  function automatic logic [3:0] model_wait(input int d, input logic [15:0] l);
    if (d == 0) return 4'd0;
    if (d == 1) return 4'd3;
    return l[3:0] & 4'b0011;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    logic [31:0] w, r;
    w = addr & ~32'd3;
    r = '0;
    if (w < MEM) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_m.exists(d * MEM + int'(w) + i)) r[8*i +: 8] = ram_m[d * MEM + int'(w) + i];
      end
    end
    return r;
  endfunction

  task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] w;
    w = addr & ~32'd3;
    if (w < MEM) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ram_m[d * MEM + int'(w) + i] = data[8*i +: 8];
    end
  endtask

  always @(posedge clock) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        busy[d]   = 0;
        m_wait[d] = model_wait(d, SEED);
      end else if (mem_valid[d] && mem_ready[d]) begin
        check($sformatf("wait_cycles_dev%0d", d), 32'(busy[d]), 32'(m_wait[d]));
        if (d == 2 && busy[d] < 4) waits_seen[busy[d]] = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready_dev%0d: got handshake expected none", d);
        end else begin
          e = sb_q.pop_front();
          check("handshake_dev", 32'(d), 32'(e.dev));
          if (e.is_read) check($sformatf("rdata_dev%0d", d), mem_rdata[d], e.rdata);
        end
        busy[d]   = 0;
        m_wait[d] = model_wait(d, m_lfsr);
      end else if (mem_valid[d]) begin
        busy[d]++;
      end
    end
    if (!reset && con_valid[1]) con_seen.push_back(con_data[1]);
  end

  // ---------------- driver ----------------
  task automatic access(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic insn, input int drop_len,
                        output int lat);
    exp_t e;
    int   cyc;
    bit   done;
    e.dev     = d;
    e.is_read = (strb == 4'h0);
    e.rdata   = model_read(d, addr);
    sb_q.push_back(e);
    @(posedge clock); #1;
    mem_addr[d]  = addr;
    mem_wdata[d] = wdata;
    mem_wstrb[d] = strb;
    mem_insn[d]  = insn;
    mem_valid[d] = 1'b1;
    cyc  = 0;
    done = 0;
    lat  = -1;
    while (!done && cyc < 64) begin
      @(negedge clock);
      if (mem_valid[d] && mem_ready[d]) begin
        done = 1;
        lat  = cyc;
      end else begin
        @(posedge clock); #1;
        cyc++;
        mem_valid[d] = !(drop_len > 0 && cyc >= 1 && cyc <= drop_len);
      end
    end
    @(posedge clock); #1;
    mem_valid[d] = 1'b0;
    mem_wstrb[d] = 4'h0;
    mem_insn[d]  = 1'b0;
    if (done) begin
      if (strb != 4'h0) model_write(d, addr, wdata, strb);
    end else begin
      void'(sb_q.pop_back());
      checks++;
      errors++;
      $display("FAIL timeout_dev%0d: got no mem_ready expected one within 64 cycles", d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, k, tries;
    logic [31:0] a;
    for (int d = 0; d < 3; d++) begin
      mem_addr[d]  = '0;
      mem_wdata[d] = '0;
      mem_wstrb[d] = '0;
    end

    repeat (3) @(posedge clock);
    #1 mem_valid[0] = 1'b1;
    @(negedge clock);
    check("ready_in_reset", 32'(mem_ready[0]), 32'd0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_flags_dev%0d", d),
            {20'd0, con_valid[d], eof[d], stalled[d], bus_err[d], con_data[d]}, 32'd0);
      check($sformatf("reset_fetch_dev%0d", d), fetch_cnt[d], 32'd0);
    end
    @(posedge clock); #1;
    mem_valid[0] = 1'b0;
    reset        = 1'b0;

    // Zero-wait device: same-cycle completion and full-word readback.
    access(0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 0, lat);
    check("mode0_write_latency", 32'(lat), 32'd0);
    access(0, 32'h100, 32'h0, 4'h0, 1'b0, 0, lat);
    check("mode0_read_latency", 32'(lat), 32'd0);

    // Byte-lane merge; expectation comes from the byte model.
    access(0, 32'h200, 32'h11223344, 4'hF, 1'b0, 0, lat);
    access(0, 32'h200, 32'hAABBCCDD, 4'b0101, 1'b0, 0, lat);
    access(0, 32'h202, 32'h0, 4'h0, 1'b0, 0, lat);

    // Unmapped access, then watchdog.
    check("bus_err_before", 32'(bus_err[0]), 32'd0);
    access(0, 32'h0020_0004, 32'h0, 4'h0, 1'b0, 0, lat);
    check("bus_err_after", 32'(bus_err[0]), 32'd1);
    repeat (90) @(negedge clock);
    check("stalled_early", 32'(stalled[0]), 32'd0);
    repeat (20) @(negedge clock);
    check("stalled_late", 32'(stalled[0]), 32'd1);

    // Fixed three-cycle waits, including a two-cycle drop mid-wait.
    access(1, 32'h0, 32'h12345678, 4'hF, 1'b0, 0, lat);
    check("mode1_first_latency", 32'(lat), 32'd3);
    access(1, 32'h0, 32'h0, 4'h0, 1'b0, 0, lat);
    check("mode1_read_latency", 32'(lat), 32'd3);
    access(1, 32'h0, 32'h0, 4'h0, 1'b0, 2, lat);
    check("mode1_drop_latency", 32'(lat), 32'd5);

    // Console bytes, then the EOF marker.
    access(1, CON, 32'h0000_0048, 4'b0001, 1'b0, 0, lat);
    access(1, CON, 32'hFFFF_FF69, 4'b0001, 1'b0, 0, lat);
    @(negedge clock);
    check("eof_before_zero", 32'(eof[1]), 32'd0);
    access(1, CON, 32'h0000_0000, 4'b0001, 1'b0, 0, lat);
    access(1, CON, 32'h0, 4'h0, 1'b0, 0, lat);
    @(negedge clock);
    check("eof_after_zero", 32'(eof[1]), 32'd1);
    check("console_bus_err", 32'(bus_err[1]), 32'd0);
    check("console_count", 32'(con_seen.size()), 32'd2);
    if (con_seen.size() == 2) begin
      check("console_byte0", 32'(con_seen[0]), 32'h48);
      check("console_byte1", 32'(con_seen[1]), 32'h69);
    end

    // Random waits: seed a window, then 1000 instruction fetches.
    for (int n = 0; n < 32; n++)
      access(2, 32'h400 + 32'(n * 4), $urandom, 4'hF, 1'b0, 0, lat);
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(31, 0);
      access(2, 32'h400 + 32'(k * 4), $urandom, 4'($urandom_range(15, 1)), 1'b0, 0, lat);
    end
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(31, 0);
      a = 32'h400 + 32'(k * 4) + 32'($urandom_range(3, 0));
      repeat ($urandom_range(2, 0)) @(posedge clock);
      access(2, a, 32'h0, 4'h0, 1'b1, 0, lat);
    end
    check("fetch_cnt_1000", fetch_cnt[2], 32'd1000);
    check("waits_all_seen", 32'(waits_seen), 32'hF);

    // Reset while a write is still waiting: the target must keep its old value.
    access(2, 32'h300, 32'h55555555, 4'hF, 1'b0, 0, lat);
    tries = 0;
    while (m_wait[2] == 4'd0 && tries < 50) begin
      access(2, 32'h400, 32'h0, 4'h0, 1'b0, 0, lat);
      tries++;
    end
    check("midwait_found", 32'(m_wait[2] != 4'd0), 32'd1);
    @(posedge clock); #1;
    mem_addr[2]  = 32'h300;
    mem_wdata[2] = 32'hAAAAAAAA;
    mem_wstrb[2] = 4'hF;
    mem_valid[2] = 1'b1;
    @(negedge clock);
    check("midwait_not_ready", 32'(mem_ready[2]), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("midwait_ready_in_reset", 32'(mem_ready[2]), 32'd0);
    @(posedge clock); #1;
    mem_valid[2] = 1'b0;
    mem_wstrb[2] = 4'h0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("fetch_cnt_after_reset", fetch_cnt[2], 32'd0);
    access(2, 32'h300, 32'h0, 4'h0, 1'b0, 0, lat);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got still running expected finish by 500000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
